// File: rtl/inst_axi_responder_pkg.sv
// rtl/inst_axi_responder_pkg.sv - AXI read constants shared by the instruction fetch responder
package inst_axi_responder_pkg;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [3:0] AXI_ID_DEFAULT = 4'd0;

endpackage

// File: rtl/inst_axi_responder_resp_order_fifo.sv
// rtl/inst_axi_responder_resp_order_fifo.sv - in-order ring of per-request cancel flags
module inst_axi_responder_resp_order_fifo #(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_idx_i,
  output logic          head_flag_o,
  output logic [AW-1:0] head_idx_o,
  output logic [AW-1:0] tail_idx_o,
  output logic [AW:0]   count_o
);

  logic [DEPTH-1:0] flag_q, flag_d;
  logic [AW:0]      head_q, head_d;
  logic [AW:0]      tail_q, tail_d;

  always_comb begin
    flag_d = flag_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push_i) begin
      flag_d[tail_q[AW-1:0]] = 1'b0;
      tail_d = tail_q + 1'b1;
    end
    // A cancel always targets an older slot than the one being pushed
    if (set_en_i) begin
      flag_d[set_idx_i] = 1'b1;
    end
    if (pop_i) begin
      head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flag_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      flag_q <= flag_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign head_idx_o  = head_q[AW-1:0];
  assign tail_idx_o  = tail_q[AW-1:0];
  assign head_flag_o = flag_q[head_q[AW-1:0]];
  assign count_o     = tail_q - head_q;

endmodule

// File: rtl/inst_axi_responder.sv
// rtl/inst_axi_responder.sv - turns fetch requests into single-beat AXI reads, answered in order
module inst_axi_responder
  import inst_axi_responder_pkg::*;
#(
  parameter int         DEPTH  = 2,
  parameter logic [3:0] AXI_ID = AXI_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_valid,
  input  logic        inst_op,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  input  logic [31:0] inst_addr,
  input  logic        inst_uncache_en,
  input  logic        tlb_excp_cancel_req,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  output logic        icache_miss,
  output logic        inst_bus_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic          arvalid_q, arvalid_d;
  logic [31:0]   araddr_q, araddr_d;
  logic [AW-1:0] last_acc_ptr_q, last_acc_ptr_d;
  logic          last_acc_valid_q, last_acc_valid_d;

  logic          push, pop, cancel_set, late_cancel;
  logic          head_flag;
  logic [AW-1:0] head_idx, tail_idx;
  logic [AW:0]   count;

  // Writes, ID and cacheability never change how a fetch is serviced
  logic unused_inputs;
  assign unused_inputs = ^{inst_op, inst_wstrb, inst_wdata, inst_uncache_en, rid};

  inst_axi_responder_resp_order_fifo #(.DEPTH(DEPTH)) u_order (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (push),
    .pop_i       (pop),
    .set_en_i    (cancel_set),
    .set_idx_i   (last_acc_ptr_q),
    .head_flag_o (head_flag),
    .head_idx_o  (head_idx),
    .tail_idx_o  (tail_idx),
    .count_o     (count)
  );

  assign inst_addr_ok = resetn && inst_valid && !arvalid_q && (count < FULL_CNT);
  assign push         = inst_addr_ok;
  assign rready       = (count != '0);
  assign pop          = rvalid && rready && rlast;
  assign cancel_set   = tlb_excp_cancel_req && last_acc_valid_q;
  // Cancel landing on the very beat being retired must mask it this cycle
  assign late_cancel  = cancel_set && (last_acc_ptr_q == head_idx);

  assign inst_data_ok = pop && !head_flag && !late_cancel;
  assign inst_rdata   = rdata;
  assign inst_bus_err = inst_data_ok && (rresp != AXI_RESP_OKAY);
  assign icache_miss  = inst_data_ok;

  assign arid    = AXI_ID;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;

  always_comb begin
    arvalid_d        = arvalid_q;
    araddr_d         = araddr_q;
    last_acc_ptr_d   = last_acc_ptr_q;
    last_acc_valid_d = push;
    if (arvalid_q && arready) begin
      arvalid_d = 1'b0;
    end
    if (push) begin
      arvalid_d      = 1'b1;
      araddr_d       = inst_addr;
      last_acc_ptr_d = tail_idx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid_q        <= 1'b0;
      araddr_q         <= '0;
      last_acc_ptr_q   <= '0;
      last_acc_valid_q <= 1'b0;
    end else begin
      arvalid_q        <= arvalid_d;
      araddr_q         <= araddr_d;
      last_acc_ptr_q   <= last_acc_ptr_d;
      last_acc_valid_q <= last_acc_valid_d;
    end
  end

endmodule
